edge_tick_array: RTL and testbench

Multi-channel, parametrised edge-to-tick converter. Each of `CH` input levels is glitch-filtered by a per-channel four-state FSM. Each accepted rising or falling transition produces a single-cycle tick, in either Mealy timing (same cycle as acceptance) or Moore timing (one cycle later). The block sits between raw level sources (buttons, status lines) and the control logic that consumes single-cycle events, and keeps a saturating event count.

---
 rtl/edge_tick_array.sv | 168 ++++++++++++++++
 tb/tb_edge_tick_array.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_tick_array.sv
// edge_tick_array: per-channel glitch-filtered edge detector with Mealy/Moore single-cycle ticks
// and a saturating event counter. Define EDGE_TICK_SYNC_EN to add a 2-flop synchroniser per input.
module edge_tick_array #(
    parameter int CH            = 4,
    parameter int FILTER_CYCLES = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CH-1:0] level,
    input  logic [1:0]    edge_sel,
    input  logic          mode,
    input  logic          clr_count,
    output logic [CH-1:0] rise_tick,
    output logic [CH-1:0] fall_tick,
    output logic          any_tick,
    output logic [15:0]   event_count
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW,
        RISE_PEND,
        HIGH,
        FALL_PEND
    } filt_state_t;

    logic [CH-1:0] s;

`ifdef EDGE_TICK_SYNC_EN
    logic [CH-1:0] sync_meta;
    logic [CH-1:0] sync_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_out  <= '0;
        end else begin
            sync_meta <= level;
            sync_out  <= sync_meta;
        end
    end

    assign s = sync_out;
`else
    assign s = level;
`endif

    filt_state_t   state_q [CH];
    filt_state_t   state_d [CH];
    logic [CW-1:0] cnt_q   [CH];
    logic [CW-1:0] cnt_d   [CH];
    logic [CH-1:0] accept_rise;
    logic [CH-1:0] accept_fall;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= LOW;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        accept_rise = '0;
        accept_fall = '0;
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                LOW: begin
                    if (s[i]) begin
                        if (FILTER_CYCLES == 1) begin
                            state_d[i]     = HIGH;
                            accept_rise[i] = 1'b1;
                        end else begin
                            state_d[i] = RISE_PEND;
                            cnt_d[i]   = CW'(1);
                        end
                    end
                end
                RISE_PEND: begin
                    if (!s[i]) begin
                        state_d[i] = LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]     = HIGH;
                        cnt_d[i]       = '0;
                        accept_rise[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                HIGH: begin
                    if (!s[i]) begin
                        if (FILTER_CYCLES == 1) begin
                            state_d[i]     = LOW;
                            accept_fall[i] = 1'b1;
                        end else begin
                            state_d[i] = FALL_PEND;
                            cnt_d[i]   = CW'(1);
                        end
                    end
                end
                FALL_PEND: begin
                    if (s[i]) begin
                        state_d[i] = HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]     = LOW;
                        cnt_d[i]       = '0;
                        accept_fall[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: begin
                    state_d[i] = LOW;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Gating with reset_n keeps the combinational Mealy path quiet while reset is held.
    logic [CH-1:0] qual_rise;
    logic [CH-1:0] qual_fall;
    logic [CH-1:0] moore_rise_q;
    logic [CH-1:0] moore_fall_q;

    assign qual_rise = accept_rise & {CH{edge_sel[0] & reset_n}};
    assign qual_fall = accept_fall & {CH{edge_sel[1] & reset_n}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            moore_rise_q <= '0;
            moore_fall_q <= '0;
        end else begin
            moore_rise_q <= qual_rise;
            moore_fall_q <= qual_fall;
        end
    end

    // Both timing paths always run; mode only picks which one is visible.
    assign rise_tick = mode ? moore_rise_q : qual_rise;
    assign fall_tick = mode ? moore_fall_q : qual_fall;
    assign any_tick  = (|rise_tick) | (|fall_tick);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_count <= '0;
        end else if (clr_count) begin
            event_count <= '0;
        end else if (any_tick && (event_count != 16'hFFFF)) begin
            event_count <= event_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_edge_tick_array.sv
// tb_edge_tick_array: directed stimulus against a sample-run-count model of the filter,
// compared every cycle, plus hand-computed tick positions and counter values.
`timescale 1ns/1ps
module tb_edge_tick_array;

    localparam int CH = 4;
    localparam int FC = 3;
`ifdef EDGE_TICK_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic          clk;
    logic          reset_n;
    logic [CH-1:0] level;
    logic [1:0]    edge_sel;
    logic          mode;
    logic          clr_count;
    logic [CH-1:0] rise_tick;
    logic [CH-1:0] fall_tick;
    logic          any_tick;
    logic [15:0]   event_count;

    edge_tick_array #(.CH(CH), .FILTER_CYCLES(FC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .level       (level),
        .edge_sel    (edge_sel),
        .mode        (mode),
        .clr_count   (clr_count),
        .rise_tick   (rise_tick),
        .fall_tick   (fall_tick),
        .any_tick    (any_tick),
        .event_count (event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: accepted level per channel and the length of the current run of differing samples.
    bit          m_lvl [CH];
    int          m_run [CH];
    bit [CH-1:0] m_moore_r;
    bit [CH-1:0] m_moore_f;
    int          m_count;
    bit [CH-1:0] m_sync1;
    bit [CH-1:0] m_sync2;

    function automatic bit [CH-1:0] m_sample();
`ifdef EDGE_TICK_SYNC_EN
        return m_sync2;
`else
        return bit'(level) ? level : level;
`endif
    endfunction

    function automatic void m_ticks(output bit [CH-1:0] r, output bit [CH-1:0] f);
        bit [CH-1:0] smp;
        smp = m_sample();
        r = '0;
        f = '0;
        if (reset_n !== 1'b1) return;
        for (int i = 0; i < CH; i++) begin
            if (smp[i] != m_lvl[i] && m_run[i] + 1 == FC) begin
                if (smp[i]) r[i] = edge_sel[0];
                else        f[i] = edge_sel[1];
            end
        end
    endfunction

    task automatic model_step();
        bit [CH-1:0] smp, r, f, shown;
        if (reset_n !== 1'b1) begin
            for (int i = 0; i < CH; i++) begin
                m_lvl[i] = 1'b0;
                m_run[i] = 0;
            end
            m_moore_r = '0;
            m_moore_f = '0;
            m_count   = 0;
            m_sync1   = '0;
            m_sync2   = '0;
            return;
        end
        smp = m_sample();
        m_ticks(r, f);
        shown = mode ? (m_moore_r | m_moore_f) : (r | f);
        for (int i = 0; i < CH; i++) begin
            if (smp[i] != m_lvl[i]) begin
                if (m_run[i] + 1 == FC) begin
                    m_lvl[i] = smp[i];
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (clr_count)                          m_count = 0;
        else if (shown != '0 && m_count < 65535) m_count++;
        m_moore_r = r;
        m_moore_f = f;
        m_sync2   = m_sync1;
        m_sync1   = level;
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    initial forever begin
        bit [CH-1:0] r, f, er, ef;
        @(negedge clk);
        m_ticks(r, f);
        er = mode ? m_moore_r : r;
        ef = mode ? m_moore_f : f;
        check("rise_tick", rise_tick, er);
        check("fall_tick", fall_tick, ef);
        check("any_tick", any_tick, (er | ef) != '0);
        check("event_count", event_count, m_count);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input int ch, input bit rise, input int n,
                         output logic [15:0] pat, output logic [15:0] apat);
        pat  = '0;
        apat = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            pat[c]  = rise ? rise_tick[ch] : fall_tick[ch];
            apat[c] = any_tick;
            cyc();
        end
    endtask

    initial begin
        logic [15:0] pat, apat;
        int ph;
        reset_n   = 1'b0;
        level     = '0;
        edge_sel  = 2'b11;
        mode      = 1'b0;
        clr_count = 1'b0;
        #3;
        check("reset_rise", rise_tick, 0);
        check("reset_fall", fall_tick, 0);
        check("reset_any", any_tick, 0);
        check("reset_count", event_count, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) cyc();

        // Mealy rise on channel 0: tick on the third sampled high
        level[0] = 1'b1;
        watch(0, 1'b1, 8, pat, apat);
        check("mealy_rise0_pos", pat, 16'h1 << (2 + LAT));
        check("mealy_count", event_count, 1);

        // Moore rise on channel 3: one cycle later, any_tick follows
        mode     = 1'b1;
        level[3] = 1'b1;
        watch(3, 1'b1, 8, pat, apat);
        check("moore_rise3_pos", pat, 16'h1 << (3 + LAT));
        check("moore_any_pos", apat, 16'h1 << (3 + LAT));
        check("moore_count", event_count, 2);
        mode = 1'b0;

        // Two-sample glitch on channel 1, then a real rise
        level[1] = 1'b1;
        cyc();
        cyc();
        level[1] = 1'b0;
        watch(1, 1'b1, 8, pat, apat);
        check("glitch_rise1", pat, 0);
        check("glitch_any", apat, 0);
        check("glitch_count", event_count, 2);
        level[1] = 1'b1;
        watch(1, 1'b1, 8, pat, apat);
        check("rise1_pos", pat, 16'h1 << (2 + LAT));
        check("rise1_count", event_count, 3);

        // Falling-only enable on channel 2
        edge_sel = 2'b10;
        level[2] = 1'b1;
        watch(2, 1'b1, 8, pat, apat);
        check("fall_only_norise", pat, 0);
        check("fall_only_noany", apat, 0);
        level[2] = 1'b0;
        watch(2, 1'b0, 8, pat, apat);
        check("fall_only_fall2", pat, 16'h1 << (2 + LAT));
        check("fall_only_count", event_count, 4);

        // Channels 0 and 3 accept together: one count
        edge_sel = 2'b11;
        level[0] = 1'b0;
        level[3] = 1'b0;
        repeat (2 + LAT) cyc();
        @(negedge clk);
        check("pair_fall_bits", fall_tick, 4'b1001);
        check("pair_any", any_tick, 1);
        repeat (4) cyc();
        check("pair_count", event_count, 5);

        // Tick every cycle until saturation
        ph = 0;
        for (int c = 0; c < 70000 && m_count < 65535; c++) begin
            level[ph] = ~level[ph];
            ph = (ph + 1) % 3;
            cyc();
        end
        repeat (6) begin
            level[ph] = ~level[ph];
            ph = (ph + 1) % 3;
            cyc();
        end
        check("sat_count", event_count, 16'hFFFF);

        // Clear in a tick cycle wins over the increment
        @(negedge clk);
        check("clr_tick_cycle", any_tick, 1);
        clr_count = 1'b1;
        cyc();
        clr_count = 1'b0;
        level[ph] = ~level[ph];
        ph = (ph + 1) % 3;
        @(negedge clk);
        check("clr_count", event_count, 0);
        cyc();
        level = '0;
        repeat (8 + LAT) cyc();

        // Reset during a pending rise, release with the level still high
        level[0] = 1'b1;
        cyc();
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_rise", rise_tick, 0);
        check("rst_mid_any", any_tick, 0);
        check("rst_mid_count", event_count, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        watch(0, 1'b1, 8, pat, apat);
        check("post_rst_rise0", pat, 16'h1 << (2 + LAT));
        check("post_rst_count", event_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
